axis_pack_in_stage: RTL and testbench

- Ingress end of the stream packer. Accepts the user AXI-Stream and buffers it in a small FIFO.
- Feeds one flit per cycle into the banyan packing network, tagging each flit with its valid-byte count and its byte offset within the output word.
- Honours output_pause, which the packer output FIFO raises when half full. This is the network's only flow control: the network has no ready and no clock enable.

---
 rtl/axis_pack_in_stage_if.sv | 38 +++
 rtl/axis_pack_in_stage.sv | 111 +++++++++++
 tb/tb_axis_pack_in_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pack_in_stage_if.sv
// Bus bundle for the packer ingress stage: user AXI-Stream in, flit stream
// out towards the banyan packing network, plus the network's pause input.
interface axis_pack_in_stage_if #(
  parameter int N_BYTES_IN  = 4,
  parameter int N_BYTES_OUT = 4
);
  localparam int DWIDTH_IN = 8 * N_BYTES_IN;
  localparam int NB_W      = $clog2(N_BYTES_IN + 1);
  localparam int OFF_W     = (N_BYTES_OUT > 1) ? $clog2(N_BYTES_OUT) : 1;

  logic [DWIDTH_IN-1:0]  s_axis_tdata;
  logic [N_BYTES_IN-1:0] s_axis_tkeep;
  logic                  s_axis_tlast;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  output_pause;

  logic [DWIDTH_IN-1:0]  int_tdata;
  logic [N_BYTES_IN-1:0] int_tkeep;
  logic                  int_tlast;
  logic                  int_tvalid;
  logic [NB_W-1:0]       int_nbytes;
  logic [OFF_W-1:0]      int_offset;

  // Stage side
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, output_pause,
    output s_axis_tready,
    output int_tdata, int_tkeep, int_tlast, int_tvalid, int_nbytes, int_offset
  );

  // Source / network side
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, output_pause,
    input  s_axis_tready,
    input  int_tdata, int_tkeep, int_tlast, int_tvalid, int_nbytes, int_offset
  );
endinterface

// File: rtl/axis_pack_in_stage.sv
// Ingress stage of the stream packer: buffers user AXI-Stream flits in a small
// FIFO and issues one flit per cycle into the packing network, tagged with its
// valid-byte count and its byte offset within the output word.
module axis_pack_in_stage #(
  parameter int N_BYTES_IN  = 4,
  parameter int N_BYTES_OUT = 4,
  parameter int DWIDTH_IN   = 32,
  parameter int DEPTH       = 16
) (
  input logic                 clk,
  input logic                 rst,
  axis_pack_in_stage_if.slave bus
);
  localparam int NB_W    = $clog2(N_BYTES_IN + 1);
  localparam int OFF_W   = (N_BYTES_OUT > 1) ? $clog2(N_BYTES_OUT) : 1;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = 1 + NB_W + N_BYTES_IN + DWIDTH_IN;

  function automatic logic [NB_W-1:0] popcount(input logic [N_BYTES_IN-1:0] k);
    logic [NB_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_BYTES_IN; i++) begin
      c = c + NB_W'(k[i]);
    end
    return c;
  endfunction

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [OFF_W-1:0]   p_q;

  logic                  full;
  logic                  empty;
  logic                  hs;
  logic                  push;
  logic                  pop;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    head;
  logic                  head_last;
  logic [NB_W-1:0]       head_nbytes;
  logic [N_BYTES_IN-1:0] head_keep;
  logic [DWIDTH_IN-1:0]  head_data;
  logic [OFF_W-1:0]      p_next;

  // Occupancy decode, handshake qualification and byte-pointer arithmetic
  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    bus.s_axis_tready = !rst && !full;
    hs        = bus.s_axis_tvalid && bus.s_axis_tready;
    // Empty non-last flits carry nothing and are swallowed at the door.
    push      = hs && ((bus.s_axis_tkeep != '0) || bus.s_axis_tlast);
    pop       = !empty && !bus.output_pause;
    wr_entry  = {bus.s_axis_tlast, popcount(bus.s_axis_tkeep),
                 bus.s_axis_tkeep, bus.s_axis_tdata};
    head      = mem[rd_ptr];
    {head_last, head_nbytes, head_keep, head_data} = head;
    if (N_BYTES_OUT == 1 || head_last) begin
      p_next = '0;
    end else begin
      p_next = OFF_W'({{NB_W{1'b0}}, p_q} + {{OFF_W{1'b0}}, head_nbytes});
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Registered flit issue towards the network; fields hold when not issuing
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q            <= '0;
      bus.int_tvalid <= 1'b0;
      bus.int_tdata  <= '0;
      bus.int_tkeep  <= '0;
      bus.int_tlast  <= 1'b0;
      bus.int_nbytes <= '0;
      bus.int_offset <= '0;
    end else begin
      bus.int_tvalid <= pop;
      if (pop) begin
        bus.int_tdata  <= head_data;
        bus.int_tkeep  <= head_keep;
        bus.int_tlast  <= head_last;
        bus.int_nbytes <= head_nbytes;
        bus.int_offset <= p_q;
        p_q            <= p_next;
      end
    end
  end
endmodule

// File: tb/tb_axis_pack_in_stage.sv
// Randomised and directed bench for the packer ingress stage, checked every
// cycle against a queue-based reference model.
module tb_axis_pack_in_stage;
  localparam int NBI   = 4;
  localparam int NBO   = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } flit_t;

  typedef struct {
    int off;
    int nb;
    int last;
  } issued_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_pack_in_stage_if #(.N_BYTES_IN(NBI), .N_BYTES_OUT(NBO)) bus ();

  axis_pack_in_stage #(
    .N_BYTES_IN (NBI),
    .N_BYTES_OUT(NBO),
    .DWIDTH_IN  (8 * NBI),
    .DEPTH      (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  flit_t   mq[$];
  int      mp = 0;
  logic    e_valid = 0;
  logic [31:0] e_data = 0;
  logic [3:0]  e_keep = 0;
  logic        e_last = 0;
  int      e_nb  = 0;
  int      e_off = 0;

  issued_t dut_log[$];
  issued_t mdl_log[$];
  logic    hs_dut;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, check outputs
  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic [3:0] k, input logic l, input logic p);
    logic  m_tready;
    flit_t f;
    rst = r;
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = l;
    bus.output_pause  = p;
    #1;
    m_tready = !r && (mq.size() < DEPTH);
    chk("tready", 64'(bus.s_axis_tready), 64'(m_tready));
    hs_dut = v && bus.s_axis_tready;
    if (r) begin
      mq.delete();
      mp = 0;
      e_valid = 0; e_data = 0; e_keep = 0; e_last = 0; e_nb = 0; e_off = 0;
    end else begin
      if (mq.size() != 0 && !p) begin
        f = mq.pop_front();
        e_valid = 1;
        e_data  = f.data;
        e_keep  = f.keep;
        e_last  = f.last;
        e_nb    = $countones(f.keep);
        e_off   = mp;
        mp      = f.last ? 0 : (mp + e_nb) % NBO;
        mdl_log.push_back('{off: e_off, nb: e_nb, last: int'(e_last)});
      end else begin
        e_valid = 0;
      end
      if (v && m_tready && (k != 4'h0 || l)) begin
        mq.push_back('{data: d, keep: k, last: l});
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("int_tvalid", 64'(bus.int_tvalid), 64'(e_valid));
    chk("int_tdata",  64'(bus.int_tdata),  64'(e_data));
    chk("int_tkeep",  64'(bus.int_tkeep),  64'(e_keep));
    chk("int_tlast",  64'(bus.int_tlast),  64'(e_last));
    chk("int_nbytes", 64'(bus.int_nbytes), 64'(e_nb));
    chk("int_offset", 64'(bus.int_offset), 64'(e_off));
    if (bus.int_tvalid) begin
      dut_log.push_back('{off: int'(bus.int_offset), nb: int'(bus.int_nbytes),
                          last: int'(bus.int_tlast)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int acc;
    int nvalid;
    int first_v;
    int last_v;
    int exp_off[5];
    bus.s_axis_tvalid = 0;
    bus.s_axis_tdata  = 0;
    bus.s_axis_tkeep  = 0;
    bus.s_axis_tlast  = 0;
    bus.output_pause  = 0;
    @(negedge clk);

    // Reset held three cycles with traffic offered
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
      chk("rst_tready_low", 64'(bus.s_axis_tready), 64'd0);
      chk("rst_tvalid_low", 64'(bus.int_tvalid), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("tready_after_rst", 64'(bus.s_axis_tready), 64'd1);

    // Single flit: visible two cycles after the handshake
    step(1'b0, 1'b1, 32'hA1B2C3D4, 4'hF, 1'b1, 1'b0);
    chk("single_t1_tvalid", 64'(bus.int_tvalid), 64'd0);
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("single_t2_tvalid", 64'(bus.int_tvalid), 64'd1);
    chk("single_tdata", 64'(bus.int_tdata), 64'hA1B2C3D4);
    chk("single_nbytes", 64'(bus.int_nbytes), 64'd4);
    chk("single_offset", 64'(bus.int_offset), 64'd0);
    idle(2);

    // Offset tracking across a packet and into the next one
    dut_log.delete(); mdl_log.delete();
    step(1'b0, 1'b1, 32'h11111111, 4'h7, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h22222222, 4'h5, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h33333333, 4'hF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h44444444, 4'h1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h55555555, 4'hF, 1'b1, 1'b0);
    idle(4);
    exp_off = '{0, 3, 1, 1, 0};
    chk("offs_dut_count", 64'(dut_log.size()), 64'd5);
    chk("offs_mdl_count", 64'(mdl_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < dut_log.size()) chk($sformatf("offs_dut_%0d", i), 64'(dut_log[i].off), 64'(exp_off[i]));
      if (i < mdl_log.size()) chk($sformatf("offs_mdl_%0d", i), 64'(mdl_log[i].off), 64'(exp_off[i]));
    end

    // Null flits: dropped unless they carry tlast
    dut_log.delete(); mdl_log.delete();
    step(1'b0, 1'b1, 32'h12345678, 4'h0, 1'b0, 1'b0);
    idle(4);
    chk("null_dropped", 64'(dut_log.size()), 64'd0);
    step(1'b0, 1'b1, 32'h87654321, 4'h0, 1'b1, 1'b0);
    idle(3);
    chk("null_last_count", 64'(dut_log.size()), 64'd1);
    if (dut_log.size() > 0) begin
      chk("null_last_nbytes", 64'(dut_log[0].nb), 64'd0);
      chk("null_last_tlast", 64'(dut_log[0].last), 64'd1);
    end

    // Backpressure: 20 offered flits against a paused, 16-deep FIFO
    dut_log.delete();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 32'hC0DE0000 + 32'(i), 4'hF, 1'b0, 1'b1);
      if (hs_dut) acc++;
    end
    chk("pause_accepts", 64'(acc), 64'd16);
    chk("pause_no_issue", 64'(dut_log.size()), 64'd0);
    nvalid = 0; first_v = -1; last_v = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      if (bus.int_tvalid) begin
        nvalid++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    chk("drain_count", 64'(nvalid), 64'd16);
    chk("drain_back_to_back", 64'(last_v - first_v), 64'd15);

    // Reset mid-packet with a nonzero byte pointer and flits buffered
    step(1'b0, 1'b1, 32'hAAAA0001, 4'h7, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'hBBBB0000 + 32'(i), 4'h3, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    dut_log.delete();
    idle(4);
    chk("rst_mid_no_issue", 64'(dut_log.size()), 64'd0);
    step(1'b0, 1'b1, 32'hCCCC0001, 4'hF, 1'b0, 1'b0);
    idle(1);
    chk("rst_mid_valid", 64'(bus.int_tvalid), 64'd1);
    chk("rst_mid_offset", 64'(bus.int_offset), 64'd0);
    idle(2);

    // Random traffic with random pause and occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) < 7),
           $urandom,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) < (((i / 300) % 2 == 0) ? 2 : 7)));
    end
    idle(DEPTH + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
